// File: rtl/vga_text_display.sv
// Text-mode VGA: 8x16 cells from an internal buffer plus an external sync font ROM, blinking cursor.
// Latency: 3 pixel ticks from counter state to rgb/sync; no backpressure, buffer writes accepted every clk.
module vga_text_display #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int TICK_DIV   = 2,
  parameter int RGB_W      = 3,
  parameter int BLINK_LOG2 = 4,
  localparam int COLS  = H_DISPLAY / 8,
  localparam int ROWS  = V_DISPLAY / 16,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [6:0]       wr_char,
  input  logic [RGB_W-1:0] wr_fg,
  input  logic [RGB_W-1:0] wr_bg,
  input  logic             cursor_en,
  input  logic [COL_W-1:0] cur_col,
  input  logic [ROW_W-1:0] cur_row,
  output logic [10:0]      font_addr,
  input  logic [7:0]       font_data,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [RGB_W-1:0] rgb,
  output logic             p_tick,
  output logic             frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(TICK_DIV);
  localparam int CELLS   = COLS * ROWS;
  localparam int AW      = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int ENT_W   = 7 + 2 * RGB_W;

  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0]         div_cnt;
  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [BLINK_LOG2:0]   frame_cnt;

  logic                  raw_von, raw_hs, raw_vs, cur_hit, wr_ok;
  logic [AW-1:0]         rd_addr, wr_addr;
  logic [ENT_W-1:0]      tbuf [CELLS];

  logic [ENT_W-1:0]      s1_cell;
  logic [2:0]            s1_xoff;
  logic [3:0]            s1_yoff;
  logic                  s1_hs, s1_vs, s1_von, s1_cur;
  logic [6:0]            s1_char;
  logic [RGB_W-1:0]      s1_fg, s1_bg;

  logic [7:0]            s2_glyph;
  logic [RGB_W-1:0]      s2_fg, s2_bg;
  logic [2:0]            s2_xoff;
  logic                  s2_hs, s2_vs, s2_von, s2_cur;
  logic                  glyph_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      p_tick  <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (p_tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt       <= '0;
            frame_cnt   <= frame_cnt + 1'b1;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign raw_von = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign raw_hs  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign raw_vs  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign cur_hit = cursor_en && frame_cnt[BLINK_LOG2]
                   && (int'(cur_row) == int'(v_cnt) / 16)
                   && (int'(cur_col) == int'(h_cnt) / 8);
  assign wr_ok   = wr_en && (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
  assign wr_addr = AW'(int'(wr_row) * COLS + int'(wr_col));

  // Blanking positions map outside the buffer, so park the read address on cell 0.
  always_comb begin
    rd_addr = '0;
    if (raw_von) rd_addr = AW'((int'(v_cnt) / 16) * COLS + int'(h_cnt) / 8);
  end

  // Buffer is not reset; a same-edge read in the pipeline below sees the old entry.
  always_ff @(posedge clk) begin
    if (wr_ok) tbuf[wr_addr] <= {wr_char, wr_fg, wr_bg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_cell <= '0;
      s1_xoff <= '0;
      s1_yoff <= '0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_von  <= 1'b0;
      s1_cur  <= 1'b0;
    end else if (p_tick) begin
      s1_cell <= tbuf[rd_addr];
      s1_xoff <= h_cnt[2:0];
      s1_yoff <= v_cnt[3:0];
      s1_hs   <= raw_hs;
      s1_vs   <= raw_vs;
      s1_von  <= raw_von;
      s1_cur  <= cur_hit;
    end
  end

  assign s1_char   = s1_cell[ENT_W-1 -: 7];
  assign s1_fg     = s1_cell[2*RGB_W-1 -: RGB_W];
  assign s1_bg     = s1_cell[RGB_W-1:0];
  assign font_addr = {s1_char, s1_yoff};

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_glyph <= '0;
      s2_fg    <= '0;
      s2_bg    <= '0;
      s2_xoff  <= '0;
      s2_hs    <= 1'b0;
      s2_vs    <= 1'b0;
      s2_von   <= 1'b0;
      s2_cur   <= 1'b0;
    end else if (p_tick) begin
      s2_glyph <= font_data;
      s2_fg    <= s1_fg;
      s2_bg    <= s1_bg;
      s2_xoff  <= s1_xoff;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      s2_von   <= s1_von;
      s2_cur   <= s1_cur;
    end
  end

  // Cursor swaps fg/bg, which is the same as inverting the glyph bit.
  assign glyph_bit = s2_glyph[3'd7 - s2_xoff] ^ s2_cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb      <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else if (p_tick) begin
      rgb      <= s2_von ? (glyph_bit ? s2_fg : s2_bg) : '0;
      hsync    <= ~s2_hs;
      vsync    <= ~s2_vs;
      video_on <= s2_von;
    end
  end

endmodule

// File: tb/tb_vga_text_display.sv
// Scoreboard bench for vga_text_display on a reduced raster with a random font ROM.
module tb_vga_text_display;
  localparam int HD = 40, HF = 2, HS = 3, HB = 3;
  localparam int VD = 48, VF = 1, VS = 2, VB = 1;
  localparam int TD = 2, RW = 3, BL = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int COLS = HD / 8, ROWS = VD / 16;
  localparam int FRAME_CLKS = HT * VT * TD;

  typedef struct {
    int          cyc;
    logic        hs;
    logic        vs;
    logic        von;
    logic [RW-1:0] rgb;
  } pix_t;

  typedef struct {
    logic [6:0]    ch;
    logic [RW-1:0] fg;
    logic [RW-1:0] bg;
  } cell_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [2:0]    wr_col;
  logic [1:0]    wr_row;
  logic [6:0]    wr_char;
  logic [RW-1:0] wr_fg, wr_bg;
  logic          cursor_en;
  logic [2:0]    cur_col;
  logic [1:0]    cur_row;
  logic [10:0]   font_addr;
  logic [7:0]    font_data;
  logic          hsync, vsync, video_on, p_tick, frame_start;
  logic [RW-1:0] rgb;

  vga_text_display #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .TICK_DIV(TD), .RGB_W(RW), .BLINK_LOG2(BL)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char),
    .wr_fg(wr_fg), .wr_bg(wr_bg),
    .cursor_en(cursor_en), .cur_col(cur_col), .cur_row(cur_row),
    .font_addr(font_addr), .font_data(font_data),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb),
    .p_tick(p_tick), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [2048];
  always @(posedge clk) font_data <= rom[font_addr];

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  pix_t  pix_q[$];
  int    fs_q[$];
  cell_t mbuf [ROWS][COLS];
  int    checks = 0, errors = 0;
  int    mh, mv, mf, rel_g;
  bit    cur_rand;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, gcyc, act, exp);
    end
  endtask

  // Reference: expected output of the pixel at (mh,mv), due 3 pixel ticks later.
  task automatic model_tick();
    pix_t  e;
    cell_t cl;
    logic [7:0] g;
    logic  b, cur;
    int    r, c;
    e.cyc = gcyc + 3 * TD;
    e.hs  = !(mh >= HD + HF && mh < HD + HF + HS);
    e.vs  = !(mv >= VD + VF && mv < VD + VF + VS);
    e.von = (mh < HD) && (mv < VD);
    e.rgb = '0;
    if (e.von) begin
      r   = mv / 16;
      c   = mh / 8;
      cl  = mbuf[r][c];
      g   = rom[{cl.ch, 4'(mv % 16)}];
      b   = g[7 - mh % 8];
      cur = cursor_en && (((mf >> BL) & 1) == 1) && int'(cur_row) == r && int'(cur_col) == c;
      e.rgb = (b ^ cur) ? cl.fg : cl.bg;
    end
    pix_q.push_back(e);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) begin
        mv = 0;
        mf++;
        fs_q.push_back(gcyc + 1);
      end
    end
  endtask

  task automatic step();
    bit tick;
    int d;
    @(negedge clk);
    wr_en   = ($urandom_range(0, 3) == 0);
    wr_col  = 3'($urandom_range(0, 7));
    wr_row  = 2'($urandom_range(0, 3));
    wr_char = 7'($urandom);
    wr_fg   = RW'($urandom);
    wr_bg   = RW'($urandom);
    if (cur_rand && $urandom_range(0, 299) == 0) cursor_en = ~cursor_en;
    if (cur_rand && $urandom_range(0, 499) == 0) begin
      cur_col = 3'($urandom_range(0, 4));
      cur_row = 2'($urandom_range(0, 2));
    end
    d = gcyc - rel_g;
    tick = (d > 0) && (d % TD == 0);
    // Deliberately collide with the cell being read on this edge.
    if (tick && mh < HD && mv < VD && $urandom_range(0, 7) == 0) begin
      wr_en  = 1'b1;
      wr_col = 3'(mh / 8);
      wr_row = 2'(mv / 16);
    end
    if (tick) model_tick();
    if (wr_en && int'(wr_col) < COLS && int'(wr_row) < ROWS)
      mbuf[wr_row][wr_col] = '{wr_char, wr_fg, wr_bg};
  endtask

  task automatic check_reset_outputs();
    check("rst_hsync", 32'(hsync), 32'(1));
    check("rst_vsync", 32'(vsync), 32'(1));
    check("rst_video_on", 32'(video_on), 32'(0));
    check("rst_rgb", 32'(rgb), 32'(0));
    check("rst_p_tick", 32'(p_tick), 32'(0));
    check("rst_frame_start", 32'(frame_start), 32'(0));
    check("rst_font_addr", 32'(font_addr), 32'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    rel_g = gcyc;
    mh = 0; mv = 0; mf = 0;
    pix_q.delete();
    fs_q.delete();
    for (int k = 1; k <= 3; k++) pix_q.push_back('{rel_g + k * TD, 1'b1, 1'b1, 1'b0, '0});
  endtask

  // Monitor: compares whenever the DUT ticks or an expected event falls due.
  initial begin
    pix_t e;
    int   f;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (pix_q.size() > 0 && (p_tick || pix_q[0].cyc == gcyc)) begin
          e = pix_q.pop_front();
          check("p_tick_cycle", 32'(gcyc), 32'(e.cyc));
          check("p_tick", 32'(p_tick), 32'(1));
          check("hsync", 32'(hsync), 32'(e.hs));
          check("vsync", 32'(vsync), 32'(e.vs));
          check("video_on", 32'(video_on), 32'(e.von));
          check("rgb", 32'(rgb), 32'(e.rgb));
        end else if (p_tick) begin
          check("unexpected_p_tick", 32'(p_tick), 32'(0));
        end
        if (fs_q.size() > 0 && (frame_start || fs_q[0] == gcyc)) begin
          f = fs_q.pop_front();
          check("frame_start_cycle", 32'(gcyc), 32'(f));
          check("frame_start", 32'(frame_start), 32'(1));
        end else if (frame_start) begin
          check("unexpected_frame_start", 32'(frame_start), 32'(0));
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; wr_en = 1'b0; wr_col = '0; wr_row = '0;
    wr_char = '0; wr_fg = '0; wr_bg = '0;
    cursor_en = 1'b1; cur_row = 2'd2; cur_col = 3'd3; cur_rand = 1'b0;
    rel_g = 0; mh = 0; mv = 0; mf = 0;
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[16'h41 * 16] = 8'h80;
    repeat (3) @(negedge clk);

    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        wr_en  = 1'b1;
        wr_row = 2'(r);
        wr_col = 3'(c);
        if (r == 0 && c == 0) begin
          wr_char = 7'h41; wr_fg = 3'd7; wr_bg = 3'd1;
        end else begin
          wr_char = 7'($urandom); wr_fg = RW'($urandom); wr_bg = RW'($urandom);
        end
        mbuf[r][c] = '{wr_char, wr_fg, wr_bg};
      end
    end
    @(negedge clk);
    wr_en = 1'b1; wr_col = 3'd5; wr_row = 2'd0; wr_char = 7'h7f;
    @(negedge clk);
    wr_en = 1'b0;
    check_reset_outputs();

    release_reset();
    repeat (6 * FRAME_CLKS + 20) step();

    n = 0;
    while (mh != 45 && n < 4 * HT * TD) begin
      step();
      n++;
    end
    check("midline_wait_timeout", 32'(mh), 32'(45));
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0;
    pix_q.delete();
    fs_q.delete();
    @(negedge clk);
    check_reset_outputs();
    repeat (3) @(negedge clk);

    release_reset();
    cur_rand = 1'b1;
    repeat (2 * FRAME_CLKS + 20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
